// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, SR/Cause field layout and write masks.
package cp0_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_SR      = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;
    localparam logic [4:0] CP0_PRID    = 5'd15;

    localparam int SR_IM_LSB     = 10;
    localparam int SR_EXL_BIT    = 1;
    localparam int SR_IE_BIT     = 0;
    localparam int CAUSE_IP_LSB  = 10;
    localparam int CAUSE_EXC_LSB = 2;

    localparam logic [31:0] SR_WMASK = (32'h0000_003F << SR_IM_LSB)
                                     | (32'd1 << SR_EXL_BIT)
                                     | (32'd1 << SR_IE_BIT);
    localparam logic [31:0] EPC_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [15:0] rsv_hi;
        logic [5:0]  im;
        logic [7:0]  rsv_mid;
        logic        exl;
        logic        ie;
    } sr_t;

    function automatic logic [31:0] cause_word(input logic [5:0] ip, input logic [4:0] exc);
        logic [31:0] w;
        w = (32'(ip) << CAUSE_IP_LSB) | (32'(exc) << CAUSE_EXC_LSB);
        return w;
    endfunction

endpackage

// File: rtl/cp0_unit_if.sv
// CP0 port between the controller (master) and the coprocessor (slave).
interface cp0_unit_if;

    logic [5:0]  hw_int;
    logic        exl_set;
    logic        exl_clr;
    logic [31:0] epc_in;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic        int_req;
    logic [31:0] epc_out;

    modport master (
        output hw_int, exl_set, exl_clr, epc_in, we, waddr, wdata, raddr,
        input  rdata, int_req, epc_out
    );

    modport slave (
        input  hw_int, exl_set, exl_clr, epc_in, we, waddr, wdata, raddr,
        output rdata, int_req, epc_out
    );

endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer; TI is sticky once Count matches Compare and clears on any Compare write.
module cp0_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q, ti_d;

    always_comb begin
        count_d   = count_we_i ? wdata_i : count_q + 32'd1;
        compare_d = compare_we_i ? wdata_i : compare_q;
        ti_d      = ti_q;
        if (count_q == compare_q) ti_d = 1'b1;
        if (compare_we_i)         ti_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q   <= 32'd0;
            compare_q <= 32'hFFFF_FFFF;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_unit.sv
// CP0 system-control coprocessor: SR/Cause/EPC/PRId, interrupt request, mfc0/mtc0 port.
// Define CP0_TIMER_EN to add the Count/Compare timer feeding Cause.IP[15].
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID     = 32'h2023_0001,
    parameter logic [31:0] SR_RESET = 32'h0000_0000
) (
    input logic       clk,
    input logic       reset,
    cp0_unit_if.slave bus
);

    sr_t         sr_q, sr_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d;
    logic        ti;
    logic        wr_sr, wr_epc;
    logic [31:0] rdata_reg;
    logic [31:0] rdata_mux;

    assign wr_sr  = bus.we && (bus.waddr == CP0_SR);
    assign wr_epc = bus.we && (bus.waddr == CP0_EPC);

`ifdef CP0_TIMER_EN
    logic [31:0] count_val, compare_val;
    logic        wr_count, wr_compare;

    assign wr_count   = bus.we && (bus.waddr == CP0_COUNT);
    assign wr_compare = bus.we && (bus.waddr == CP0_COMPARE);

    cp0_timer u_timer (
        .clk          (clk),
        .reset        (reset),
        .count_we_i   (wr_count),
        .compare_we_i (wr_compare),
        .wdata_i      (bus.wdata),
        .count_o      (count_val),
        .compare_o    (compare_val),
        .ti_o         (ti)
    );
`else
    assign ti = 1'b0;
`endif

    // Ordering of the assignments encodes EXL priority: exl_set beats mtc0 beats exl_clr.
    always_comb begin
        sr_d = sr_q;
        if (bus.exl_clr) sr_d.exl = 1'b0;
        if (wr_sr)       sr_d = sr_t'(bus.wdata & SR_WMASK);
        if (bus.exl_set) sr_d.exl = 1'b1;

        epc_d = epc_q;
        if (wr_epc)      epc_d = bus.wdata & EPC_MASK;
        if (bus.exl_set) epc_d = bus.epc_in & EPC_MASK;

        exc_d = exc_q;
        if (bus.exl_set) exc_d = 5'd0;

        ip_d    = bus.hw_int;
        ip_d[5] = bus.hw_int[5] | ti;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q  <= sr_t'(SR_RESET & SR_WMASK);
            ip_q  <= 6'd0;
            exc_q <= 5'd0;
            epc_q <= 32'd0;
        end else begin
            sr_q  <= sr_d;
            ip_q  <= ip_d;
            exc_q <= exc_d;
            epc_q <= epc_d;
        end
    end

    // Same-cycle mtc0 to the register being read returns the value it will hold after the edge.
    always_comb begin
        rdata_reg = 32'd0;
        case (bus.raddr)
            CP0_SR:      rdata_reg = 32'(sr_q);
            CP0_CAUSE:   rdata_reg = cause_word(ip_q, exc_q);
            CP0_EPC:     rdata_reg = epc_q;
            CP0_PRID:    rdata_reg = PRID;
`ifdef CP0_TIMER_EN
            CP0_COUNT:   rdata_reg = count_val;
            CP0_COMPARE: rdata_reg = compare_val;
`endif
            default:     rdata_reg = 32'd0;
        endcase

        rdata_mux = rdata_reg;
        if (bus.we && (bus.waddr == bus.raddr)) begin
            case (bus.waddr)
                CP0_SR:      rdata_mux = bus.wdata & SR_WMASK;
                CP0_EPC:     rdata_mux = bus.wdata & EPC_MASK;
`ifdef CP0_TIMER_EN
                CP0_COUNT:   rdata_mux = bus.wdata;
                CP0_COMPARE: rdata_mux = bus.wdata;
`endif
                default:     rdata_mux = rdata_reg;
            endcase
        end
    end

    assign bus.rdata   = rdata_mux;
    assign bus.epc_out = wr_epc ? (bus.wdata & EPC_MASK) : epc_q;
    assign bus.int_req = (|(ip_q & sr_q.im)) & sr_q.ie & ~sr_q.exl;

endmodule
